// File: rtl/pattern_sweep_gen_if.sv
// Control/stimulus bundle for pattern_sweep_gen.
//   master: bench control side (drives start/mode/pause/abort, observes outputs)
//   slave : the sequencer itself
// Signals:
//   i_start, i_mode[1:0], i_pause, i_abort          control into the sequencer
//   o_pattern[WIDTH-1:0], o_pat_valid, o_sample,    stimulus and strobes out
//   o_index[$clog2(N_STEPS+1)-1:0], o_busy, o_done  progress/status out
interface pattern_sweep_gen_if #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned N_STEPS = 18
);
    localparam int unsigned IDX_W = $clog2(N_STEPS + 1);

    logic             i_start;
    logic [1:0]       i_mode;
    logic             i_pause;
    logic             i_abort;
    logic [WIDTH-1:0] o_pattern;
    logic             o_pat_valid;
    logic             o_sample;
    logic [IDX_W-1:0] o_index;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_mode, i_pause, i_abort,
        input  o_pattern, o_pat_valid, o_sample, o_index, o_busy, o_done
    );

    modport slave (
        input  i_start, i_mode, i_pause, i_abort,
        output o_pattern, o_pat_valid, o_sample, o_index, o_busy, o_done
    );
endinterface

// File: rtl/pattern_sweep_gen.sv
// Stimulus sequencer for exhaustive combinational-gate benches: sweeps an
// N-bit pattern (binary up/down, gray, walking-one), holding each value
// HOLD_CYCLES clocks and strobing o_sample on the last hold cycle.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    pattern_sweep_gen_if.slave (control in, pattern/strobes/status out)
module pattern_sweep_gen #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned N_STEPS     = 18
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pattern_sweep_gen_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(N_STEPS + 1);
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q,     state_d;
    logic [1:0]       mode_q,      mode_d;
    logic [CNT_W-1:0] hold_q,      hold_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [WIDTH-1:0] k_q,         k_d;
    logic [WIDTH-1:0] walk_q,      walk_d;
    logic [WIDTH-1:0] pattern_q,   pattern_d;
    logic             pat_valid_q, pat_valid_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             sample_c;

    logic hold_last;
    logic idx_last;
    assign hold_last = (hold_q == CNT_W'(HOLD_CYCLES - 1));
    assign idx_last  = (idx_q == IDX_W'(N_STEPS - 1));

    // Pattern for sweep position k; walking-one comes from its own rotate register.
    function automatic logic [WIDTH-1:0] pat_f(input logic [1:0]       m,
                                               input logic [WIDTH-1:0] k,
                                               input logic [WIDTH-1:0] w);
        case (m)
            2'b00:   pat_f = k;
            2'b01:   pat_f = k ^ (k >> 1);
            2'b10:   pat_f = w;
            default: pat_f = ~k;
        endcase
    endfunction

    // Next-state and strobe logic.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        k_d         = k_q;
        walk_d      = walk_q;
        pattern_d   = pattern_q;
        pat_valid_d = 1'b0;
        sample_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d     = S_DRIVE;
                    mode_d      = bus.i_mode;
                    hold_d      = '0;
                    idx_d       = '0;
                    k_d         = '0;
                    walk_d      = WIDTH'(1);
                    pattern_d   = pat_f(bus.i_mode, '0, WIDTH'(1));
                    pat_valid_d = 1'b1;
                end
            end
            S_DRIVE: begin
                if (bus.i_abort) begin
                    state_d   = S_IDLE;
                    idx_d     = '0;
                    pattern_d = '0;
                    hold_d    = '0;
                end else if (!bus.i_pause) begin
                    if (hold_last) begin
                        sample_c = 1'b1;
                        if (idx_last) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d       = idx_q + IDX_W'(1);
                            k_d         = k_q + WIDTH'(1);
                            // Walking-one restarts with the rest of the sweep when k wraps.
                            walk_d      = (k_d == '0) ? WIDTH'(1)
                                                      : {walk_q[WIDTH-2:0], walk_q[WIDTH-1]};
                            pattern_d   = pat_f(mode_q, k_d, walk_d);
                            pat_valid_d = 1'b1;
                            hold_d      = '0;
                        end
                    end else begin
                        hold_d = hold_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (bus.i_abort) begin
                    idx_d     = '0;
                    pattern_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_DRIVE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'b00;
            hold_q      <= '0;
            idx_q       <= '0;
            k_q         <= '0;
            walk_q      <= '0;
            pattern_q   <= '0;
            pat_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            walk_q      <= walk_d;
            pattern_q   <= pattern_d;
            pat_valid_q <= pat_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // o_sample must react to i_pause/i_abort in the same cycle, so it is decoded, not registered.
    assign bus.o_sample    = sample_c & ~i_rst;
    assign bus.o_pattern   = pattern_q;
    assign bus.o_pat_valid = pat_valid_q;
    assign bus.o_index     = idx_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
endmodule

// File: tb/tb_pattern_sweep_gen.sv
// Randomized bench: two sequencers (WIDTH=4; HOLD=3/N=18 and HOLD=1/N=6)
// share one random control stream and are compared every cycle against a
// step/elapsed-time reference model of the sweep.
module tb_pattern_sweep_gen;
    localparam int unsigned W   = 4;
    localparam int unsigned H_A = 3;
    localparam int unsigned N_A = 18;
    localparam int unsigned H_B = 1;
    localparam int unsigned N_B = 6;
    localparam int          N_CYC = 8000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       pause;
    logic       abort;

    always #5 clk = ~clk;

    pattern_sweep_gen_if #(.WIDTH(W), .N_STEPS(N_A)) if_a ();
    pattern_sweep_gen_if #(.WIDTH(W), .N_STEPS(N_B)) if_b ();

    assign if_a.i_start = start;
    assign if_a.i_mode  = mode;
    assign if_a.i_pause = pause;
    assign if_a.i_abort = abort;
    assign if_b.i_start = start;
    assign if_b.i_mode  = mode;
    assign if_b.i_pause = pause;
    assign if_b.i_abort = abort;

    pattern_sweep_gen #(.WIDTH(W), .HOLD_CYCLES(H_A), .N_STEPS(N_A)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_a.slave)
    );

    pattern_sweep_gen #(.WIDTH(W), .HOLD_CYCLES(H_B), .N_STEPS(N_B)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 driving, 2 done.
    int         m_hold [2] = '{H_A, H_B};
    int         m_n    [2] = '{N_A, N_B};
    int         m_phase[2];
    int         m_step [2];
    int         m_held [2];
    int         m_pat  [2];
    int         m_idx  [2];
    bit         m_pv   [2];
    logic [1:0] m_mode [2];
    int         samp_cnt[2];

    // Sweep value for a step number, straight from the mode definitions.
    function automatic int exp_pat(input logic [1:0] md, input int step);
        int k;
        k = step % (1 << W);
        case (md)
            2'b00:   return k;
            2'b01:   return k ^ (k >> 1);
            2'b10:   return 1 << (k % W);
            default: return ((1 << W) - 1) - k;
        endcase
    endfunction

    task automatic model_step(input int i);
        if (rst) begin
            m_phase[i] = 0; m_step[i] = 0; m_held[i] = 0;
            m_pat[i] = 0;   m_idx[i] = 0;  m_pv[i] = 1'b0;
        end else begin
            m_pv[i] = 1'b0;
            case (m_phase[i])
                0: if (start) begin
                    m_phase[i] = 1; m_mode[i] = mode;
                    m_step[i] = 0;  m_held[i] = 0;
                    m_pat[i] = exp_pat(mode, 0); m_idx[i] = 0;
                    m_pv[i] = 1'b1; samp_cnt[i] = 0;
                end
                1: if (abort) begin
                    m_phase[i] = 0; m_pat[i] = 0; m_idx[i] = 0;
                end else if (!pause) begin
                    if (m_held[i] == m_hold[i] - 1) begin
                        if (m_step[i] == m_n[i] - 1) begin
                            m_phase[i] = 2;
                        end else begin
                            m_step[i]++;
                            m_held[i] = 0;
                            m_pat[i]  = exp_pat(m_mode[i], m_step[i]);
                            m_idx[i]  = m_step[i];
                            m_pv[i]   = 1'b1;
                        end
                    end else begin
                        m_held[i]++;
                    end
                end
                default: begin
                    m_phase[i] = 0;
                    if (abort) begin
                        m_pat[i] = 0; m_idx[i] = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check_inst(input int i);
        logic [31:0] o_pat, o_idx;
        logic        o_pv, o_smp, o_busy, o_done;
        bit          e_smp;
        string       p;
        if (i == 0) begin
            o_pat = 32'(if_a.o_pattern); o_idx = 32'(if_a.o_index);
            o_pv = if_a.o_pat_valid; o_smp = if_a.o_sample;
            o_busy = if_a.o_busy;    o_done = if_a.o_done;
        end else begin
            o_pat = 32'(if_b.o_pattern); o_idx = 32'(if_b.o_index);
            o_pv = if_b.o_pat_valid; o_smp = if_b.o_sample;
            o_busy = if_b.o_busy;    o_done = if_b.o_done;
        end
        p = (i == 0) ? "a" : "b";
        e_smp = (m_phase[i] == 1) && (m_held[i] == m_hold[i] - 1) && !pause && !abort && !rst;
        check_eq({p, ".pattern"},   o_pat,          32'(m_pat[i]));
        check_eq({p, ".index"},     o_idx,          32'(m_idx[i]));
        check_eq({p, ".pat_valid"}, 32'(o_pv),      32'(m_pv[i]));
        check_eq({p, ".sample"},    32'(o_smp),     32'(e_smp));
        check_eq({p, ".busy"},      32'(o_busy),    32'(m_phase[i] == 1));
        check_eq({p, ".done"},      32'(o_done),    32'(m_phase[i] == 2));
        if (o_smp === 1'b1) samp_cnt[i]++;
        // A completed run must have produced exactly N_STEPS sample strobes.
        if (m_phase[i] == 2) check_eq({p, ".samples_per_run"}, 32'(samp_cnt[i]), 32'(m_n[i]));
    endtask

    initial begin
        int pause_left;
        pause_left = 0;
        rst = 1'b1; start = 1'b0; mode = 2'b00; pause = 1'b0; abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_step[i] = 0; m_held[i] = 0; m_pat[i] = 0;
            m_idx[i] = 0;   m_pv[i] = 1'b0; m_mode[i] = 2'b00; samp_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            rst   = (cyc < 2) || ($urandom_range(0, 2999) == 0);
            start = (m_phase[0] == 1 && m_phase[1] == 1) ? ($urandom_range(0, 15) == 0)
                                                         : ($urandom_range(0, 3) == 0);
            mode  = 2'($urandom_range(0, 3));
            if (pause_left == 0 && $urandom_range(0, 39) == 0) pause_left = 5;
            pause = (pause_left > 0) || ($urandom_range(0, 9) == 0);
            if (pause_left > 0) pause_left--;
            abort = ($urandom_range(0, 299) == 0);
            #1;
            check_inst(0);
            check_inst(1);
            model_step(0);
            model_step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
